// File: rtl/fwuart_baudgen.sv
// ---------------------------------------------------------------------------
// fwuart_baudgen
//   Fractional baud-rate generator for a UART. A down-counter with a
//   fractional accumulator produces an oversample tick (tick_os) whose average
//   period is div_int + div_frac/2^FRAC_WIDTH clocks. Every OS oversample
//   ticks (OS = 16, or 8 in os8 mode) a bit tick (tick_bit) is produced.
//   A new configuration is staged as "pending". It becomes active at the next
//   bit boundary, on any disabled edge, or on a resync pulse. This keeps a bit
//   period from being split between two baud rates.
//
// Ports
//   clock        in   single clock, all state on posedge
//   reset        in   asynchronous, active-high reset
//   enable       in   generator run enable (0 = hold counters cleared)
//   resync       in   one-cycle pulse, realigns phase (RX start-bit alignment)
//   cfg_we       in   one-cycle pulse, stages cfg_div_int/cfg_div_frac/cfg_os8
//   cfg_div_int  in   integer divisor part (0 behaves as 1)
//   cfg_div_frac in   fractional divisor part, units of 2^-FRAC_WIDTH
//   cfg_os8      in   oversample select of the staged config (1 = x8)
//   tick_os      out  registered oversample tick pulse
//   tick_bit     out  registered bit-period tick pulse
//   cfg_pending  out  a staged config is waiting to become active
// ---------------------------------------------------------------------------
module fwuart_baudgen #(
  parameter int unsigned CLOCKRATE   = 16000000,
  parameter int unsigned BAUDRATE    = 115200,
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned FRAC_WIDTH  = 4,
  parameter int unsigned DEFAULT_OS8 = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  resync,
  input  logic                  cfg_we,
  input  logic [DIV_WIDTH-1:0]  cfg_div_int,
  input  logic [FRAC_WIDTH-1:0] cfg_div_frac,
  input  logic                  cfg_os8,
  output logic                  tick_os,
  output logic                  tick_bit,
  output logic                  cfg_pending
);

  typedef struct packed {
    logic [DIV_WIDTH-1:0]  div_int;
    logic [FRAC_WIDTH-1:0] div_frac;
    logic                  os8;
  } cfg_t;

  // Reset divisor in 64-bit fixed point:
  // Q = CLOCKRATE * 2^FRAC_WIDTH / (BAUDRATE * OS).
  localparam logic [63:0] DEF_OS = (DEFAULT_OS8 != 0) ? 64'd8 : 64'd16;
  localparam logic [63:0] DEF_Q  =
    (64'(CLOCKRATE) << FRAC_WIDTH) / (64'(BAUDRATE) * DEF_OS);
  localparam cfg_t DEF_CFG = '{
    div_int:  DIV_WIDTH'(DEF_Q >> FRAC_WIDTH),
    div_frac: FRAC_WIDTH'(DEF_Q),
    os8:      (DEFAULT_OS8 != 0)
  };

  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic [FRAC_WIDTH-1:0] acc_q, acc_d;
  logic [3:0]            os_cnt_q, os_cnt_d;
  cfg_t                  active_q, active_d;
  cfg_t                  pend_cfg_q, pend_cfg_d;
  logic                  pend_q, pend_d;
  logic                  tick_os_q, tick_os_d;
  logic                  tick_bit_q, tick_bit_d;

  logic                  tick_slot;
  logic                  os_last;
  logic                  bit_edge;
  logic                  apply;
  logic [DIV_WIDTH-1:0]  div_eff;
  logic [FRAC_WIDTH:0]   acc_sum;

  // Apply-event detection. It uses only the currently active config, because
  // the bit boundary is decided by the OS value in force before the switch.
  always_comb begin
    tick_slot = (cnt_q == '0);
    os_last   = active_q.os8 ? (os_cnt_q == 4'd7) : (os_cnt_q == 4'd15);
    bit_edge  = enable && !resync && tick_slot && os_last;
    apply     = pend_q && (!enable || resync || bit_edge);
  end

  // Config staging. When a write coincides with an apply, the old staged
  // contents go active and the new write stays staged.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    active_d   = apply ? pend_cfg_q : active_q;
    pend_cfg_d = pend_cfg_q;
    pend_d     = pend_q && !apply;
    if (cfg_we) begin
      pend_cfg_d = '{div_int: cfg_div_int, div_frac: cfg_div_frac, os8: cfg_os8};
      pend_d     = 1'b1;
    end
  end

  // Tick datapath. A reload on an apply edge already uses the newly active
  // divisor, so the first period of the new bit runs at the new rate.
  always_comb begin
    div_eff    = (active_d.div_int == '0) ? DIV_WIDTH'(1) : active_d.div_int;
    acc_sum    = {1'b0, acc_q} + {1'b0, active_d.div_frac};
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    os_cnt_d   = os_cnt_q;
    tick_os_d  = 1'b0;
    tick_bit_d = 1'b0;
    if (!enable) begin
      // Cleared counters make the first enabled edge tick immediately.
      cnt_d    = '0;
      acc_d    = '0;
      os_cnt_d = '0;
    end else if (resync) begin
      // Restart a full period from this edge. No tick is issued even if one
      // was due.
      cnt_d    = div_eff - DIV_WIDTH'(1);
      acc_d    = '0;
      os_cnt_d = '0;
    end else if (tick_slot) begin
      tick_os_d = 1'b1;
      acc_d     = acc_sum[FRAC_WIDTH-1:0];
      // The accumulator carry stretches this period by one clock.
      cnt_d     = div_eff - DIV_WIDTH'(1) + DIV_WIDTH'(acc_sum[FRAC_WIDTH]);
      if (os_last) begin
        os_cnt_d   = '0;
        tick_bit_d = 1'b1;
      end else begin
        os_cnt_d = os_cnt_q + 4'd1;
      end
    end else begin
      cnt_d = cnt_q - DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      os_cnt_q   <= '0;
      tick_os_q  <= 1'b0;
      tick_bit_q <= 1'b0;
      pend_q     <= 1'b0;
      // NOTE: the config registers are plain flops, not memories, so they are
      // reset like the rest. The link comes up at the default baud with no
      // software write.
      active_q   <= DEF_CFG;
      pend_cfg_q <= DEF_CFG;
    end else begin
      // NOTE: non-blocking assignments; every flop samples pre-edge values.
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      os_cnt_q   <= os_cnt_d;
      tick_os_q  <= tick_os_d;
      tick_bit_q <= tick_bit_d;
      pend_q     <= pend_d;
      active_q   <= active_d;
      pend_cfg_q <= pend_cfg_d;
    end
  end

  assign tick_os     = tick_os_q;
  assign tick_bit    = tick_bit_q;
  assign cfg_pending = pend_q;

endmodule
